// File: rtl/risk_sequencer.sv
// Risk micro-op sequencer: buffers commands in a 2-deep FIFO and expands each into strided micro-ops.
// Optional build macro RISK_SEQ_PERF_EN enables the perf_ops issued-micro-op counter.
module risk_sequencer #(
  parameter int unsigned OP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_func,
  input  logic [4:0]  cmd_reg,
  input  logic [16:0] cmd_addr,
  input  logic [14:0] cmd_stride_x,
  input  logic [14:0] cmd_stride_y,
  input  logic [7:0]  cmd_count,
  input  logic [16:0] cmd_addr_step,
  output logic [2:0]  risk_func,
  output logic [4:0]  risk_reg,
  output logic [16:0] risk_addr,
  output logic [14:0] risk_stride_x,
  output logic [14:0] risk_stride_y,
  output logic        busy,
  output logic        done,
  output logic [31:0] perf_ops
);

  localparam int unsigned FUNC_W    = 3;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned STRIDE_W  = 15;
  localparam int unsigned COUNT_W   = 8;
  localparam int unsigned WAIT_W    = 4;
  localparam int unsigned WAIT_LAST = (OP_CYCLES > 1) ? OP_CYCLES - 2 : 0;
  localparam logic [FUNC_W-1:0] FUNC_NOP = '0;

  typedef struct packed {
    logic [FUNC_W-1:0]   func;
    logic [REG_W-1:0]    regn;
    logic [ADDR_W-1:0]   addr;
    logic [STRIDE_W-1:0] stride_x;
    logic [STRIDE_W-1:0] stride_y;
    logic [COUNT_W-1:0]  count;
    logic [ADDR_W-1:0]   step;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  cmd_t        fifo_mem [2];
  cmd_t        cmd_in;
  cmd_t        head;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_cnt;
  logic        push, pop, fifo_empty;

  state_t              state, state_n;
  logic [COUNT_W-1:0]  rem, rem_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic [FUNC_W-1:0]   func_q, func_q_n;
  logic [ADDR_W-1:0]   step_q, step_n;
  logic [FUNC_W-1:0]   func_n;
  logic [REG_W-1:0]    reg_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [STRIDE_W-1:0] sx_n, sy_n;
  logic                done_n;
  logic                slot_end;

  assign cmd_in = '{func: cmd_func, regn: cmd_reg, addr: cmd_addr, stride_x: cmd_stride_x,
                    stride_y: cmd_stride_y, count: cmd_count, step: cmd_addr_step};

  // Full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign cmd_ready  = (fifo_cnt != 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr];
  assign busy       = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      rem           <= '0;
      wait_cnt      <= '0;
      func_q        <= '0;
      step_q        <= '0;
      risk_func     <= '0;
      risk_reg      <= '0;
      risk_addr     <= '0;
      risk_stride_x <= '0;
      risk_stride_y <= '0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      rem           <= rem_n;
      wait_cnt      <= wait_n;
      func_q        <= func_q_n;
      step_q        <= step_n;
      risk_func     <= func_n;
      risk_reg      <= reg_n;
      risk_addr     <= addr_n;
      risk_stride_x <= sx_n;
      risk_stride_y <= sy_n;
      done          <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so each micro-op appears registered in its ISSUE cycle.
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    wait_n   = wait_cnt;
    func_q_n = func_q;
    step_n   = step_q;
    func_n   = FUNC_NOP;
    reg_n    = risk_reg;
    addr_n   = risk_addr;
    sx_n     = risk_stride_x;
    sy_n     = risk_stride_y;
    done_n   = 1'b0;
    pop      = 1'b0;
    slot_end = 1'b0;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.count == '0) begin
            done_n = 1'b1;
          end else begin
            state_n  = S_ISSUE;
            rem_n    = head.count - COUNT_W'(1);
            func_q_n = head.func;
            step_n   = head.step;
            func_n   = head.func;
            reg_n    = head.regn;
            addr_n   = head.addr;
            sx_n     = head.stride_x;
            sy_n     = head.stride_y;
          end
        end
      end
      S_ISSUE: begin
        if (OP_CYCLES > 1) begin
          state_n = S_WAIT;
          wait_n  = WAIT_W'(WAIT_LAST);
        end else begin
          slot_end = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_cnt != '0) wait_n = wait_cnt - WAIT_W'(1);
        else                slot_end = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (slot_end) begin
      if (rem != '0) begin
        state_n = S_ISSUE;
        rem_n   = rem - COUNT_W'(1);
        func_n  = func_q;
        reg_n   = risk_reg + REG_W'(1);
        addr_n  = risk_addr + step_q;
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end
  end

`ifdef RISK_SEQ_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               perf_ops <= '0;
    else if (state == S_ISSUE) perf_ops <= perf_ops + 32'd1;
  end
`else
  assign perf_ops = '0;
`endif

endmodule

// File: tb/tb_risk_sequencer.sv
// Scoreboard bench for risk_sequencer: stimulus queues expected micro-ops/done pulses, a monitor checks them.
module tb_risk_sequencer;
  localparam int OP = 4;

  typedef struct {
    int          cyc;
    logic [2:0]  func;
    logic [4:0]  rg;
    logic [16:0] addr;
    logic [14:0] sx;
    logic [14:0] sy;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_func = '0;
  logic [4:0]  cmd_reg = '0;
  logic [16:0] cmd_addr = '0;
  logic [14:0] cmd_stride_x = '0;
  logic [14:0] cmd_stride_y = '0;
  logic [7:0]  cmd_count = '0;
  logic [16:0] cmd_addr_step = '0;
  logic [2:0]  risk_func;
  logic [4:0]  risk_reg;
  logic [16:0] risk_addr;
  logic [14:0] risk_stride_x;
  logic [14:0] risk_stride_y;
  logic        busy;
  logic        done;
  logic [31:0] perf_ops;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_done = -100;
  exp_t exp_q[$];
  int   done_q[$];
  logic [4:0]  last_reg = '0;
  logic [16:0] last_addr = '0;
  logic [14:0] last_sx = '0, last_sy = '0;

  risk_sequencer #(.OP_CYCLES(OP)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_func(cmd_func), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
    .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y), .cmd_count(cmd_count),
    .cmd_addr_step(cmd_addr_step), .risk_func(risk_func), .risk_reg(risk_reg),
    .risk_addr(risk_addr), .risk_stride_x(risk_stride_x), .risk_stride_y(risk_stride_y),
    .busy(busy), .done(done), .perf_ops(perf_ops)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a command is popped in the first IDLE cycle at or after its acceptance.
  task automatic expect_cmd(input logic [2:0] f, input logic [4:0] r, input logic [16:0] a,
                            input logic [16:0] step, input int count, input logic [14:0] sx,
                            input logic [14:0] sy, input int acc);
    exp_t e;
    int t;
    t = (acc > last_done) ? acc : last_done;
    for (int i = 0; i < count; i++) begin
      e.cyc  = t + 1 + i * OP;
      e.func = f;
      e.rg   = 5'(int'(r) + i);
      e.addr = 17'(int'(a) + i * int'(step));
      e.sx   = sx;
      e.sy   = sy;
      exp_q.push_back(e);
    end
    last_done = t + 1 + count * OP;
    done_q.push_back(last_done);
  endtask

  task automatic send(input logic [2:0] f, input logic [4:0] r, input logic [16:0] a,
                      input logic [16:0] step, input int count, input logic [14:0] sx,
                      input logic [14:0] sy, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_func = f; cmd_reg = r; cmd_addr = a; cmd_addr_step = step;
    cmd_count = 8'(count); cmd_stride_x = sx; cmd_stride_y = sy;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk("send_timeout", 0, 1);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    expect_cmd(f, r, a, step, count, sx, sy, acc);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0 && done_q.size() == 0) ok = 1'b1;
    end
    chk("idle_reached", 64'(ok), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_func"}, 64'(risk_func), 0);
    chk({tag, "_reg"}, 64'(risk_reg), 0);
    chk({tag, "_addr"}, 64'(risk_addr), 0);
    chk({tag, "_sx"}, 64'(risk_stride_x), 0);
    chk({tag, "_sy"}, 64'(risk_stride_y), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_ready"}, 64'(cmd_ready), 1);
    chk({tag, "_perf"}, 64'(perf_ops), 0);
  endtask

  // Monitor: every non-NOP cycle must match the next queued micro-op; NOP cycles must hold operands.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      done_q.delete();
      last_reg = '0; last_addr = '0; last_sx = '0; last_sy = '0;
    end else begin
      if (risk_func != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_op", 64'(risk_func), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("op_cycle", 64'(cyc), 64'(e.cyc));
          chk("op_func", 64'(risk_func), 64'(e.func));
          chk("op_reg", 64'(risk_reg), 64'(e.rg));
          chk("op_addr", 64'(risk_addr), 64'(e.addr));
          chk("op_sx", 64'(risk_stride_x), 64'(e.sx));
          chk("op_sy", 64'(risk_stride_y), 64'(e.sy));
        end
        last_reg = risk_reg; last_addr = risk_addr;
        last_sx = risk_stride_x; last_sy = risk_stride_y;
      end else begin
        chk("hold_reg", 64'(risk_reg), 64'(last_reg));
        chk("hold_addr", 64'(risk_addr), 64'(last_addr));
        chk("hold_sx", 64'(risk_stride_x), 64'(last_sx));
        chk("hold_sy", 64'(risk_stride_y), 64'(last_sy));
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else                    chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  initial begin
    int a0, a1, a2, a3;

    #1 resetn = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    #1 resetn = 1'b1;

    // Perf counter over two commands straight out of reset.
    send(3'd2, 5'd5, 17'h00100, 17'h00004, 5, 15'h0011, 15'h0022, a0);
    send(3'd3, 5'd10, 17'h02000, 17'h00100, 3, 15'h0033, 15'h0044, a1);
    wait_idle();
`ifdef RISK_SEQ_PERF_EN
    chk("perf_ops", 64'(perf_ops), 8);
`else
    chk("perf_ops", 64'(perf_ops), 0);
`endif

    // Basic expansion: reg 2,3,4 / addr 34,50,66 at +1,+5,+9, done at +13.
    send(3'd1, 5'd2, 17'd34, 17'd16, 3, 15'h1234, 15'h0765, a0);
    wait_idle();

    // Back-to-back: a running command plus three queued; the last waits for a pop.
    send(3'd4, 5'd0, 17'h00040, 17'h00008, 2, 15'h0001, 15'h0002, a0);
    send(3'd5, 5'd8, 17'h00400, 17'h00010, 2, 15'h0003, 15'h0004, a1);
    send(3'd6, 5'd16, 17'h01000, 17'h00020, 2, 15'h0005, 15'h0006, a2);
    @(negedge clk);
    #1 chk("ready_when_full", 64'(cmd_ready), 0);
    chk("busy_when_full", 64'(busy), 1);
    send(3'd7, 5'd24, 17'h04000, 17'h00040, 2, 15'h0007, 15'h0008, a3);
    chk("third_accept_edge", 64'(a3 - a0), 11);
    wait_idle();

    // Register and address wrap.
    send(3'd2, 5'd31, 17'h1FFF0, 17'h00020, 2, 15'h7FFF, 15'h4000, a0);
    wait_idle();

    // Zero-count command: done only, busy drops right after the pop.
    send(3'd3, 5'd9, 17'h00777, 17'h00001, 0, 15'h0101, 15'h0202, a0);
    @(negedge clk);
    #1 chk("zero_busy_queued", 64'(busy), 1);
    @(negedge clk);
    #1 chk("zero_busy_after", 64'(busy), 0);
    wait_idle();

    // Reset while micro-op 1 of 4 is on the outputs.
    send(3'd5, 5'd12, 17'h00200, 17'h00002, 4, 15'h0A0A, 15'h0B0B, a0);
    send(3'd6, 5'd1, 17'h00300, 17'h00003, 2, 15'h0C0C, 15'h0D0D, a1);
    repeat (6) @(negedge clk);
    #1 chk("pre_reset_reg", 64'(risk_reg), 13);
    resetn = 1'b0;
    #1 chk_reset_outputs("midreset");
    last_done = -100;
    @(negedge clk);
    @(negedge clk);
    #1 resetn = 1'b1;
    send(3'd1, 5'd20, 17'h00055, 17'h00005, 2, 15'h0111, 15'h0222, a0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
